spi_bus_bridge: RTL and testbench

SPI slave front-end that turns host SPI frames into single-cycle internal bus reads and writes. It sits directly upstream of the system's peripheral address decoder, which covers BRAM, UART, mics, GPIO and NFC. The SPI pins are oversampled in the system clock domain. A frame is one 16-bit header word followed by one or more 16-bit data words, with optional address auto-increment (burst).

---
 rtl/spi_bus_bridge_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_bus_bridge.sv | 145 ++++++++++++++
 tb/tb_spi_bus_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_bridge_pkg.sv
// rtl/spi_bus_bridge_pkg.sv - shared header layout, FSM encoding and helpers for spi_bus_bridge
package spi_bus_bridge_pkg;

    localparam int WORD_BITS    = 16;
    localparam int HDR_RNW      = 0;
    localparam int HDR_AUTOINC  = 1;
    localparam int HDR_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    // Data words travel low byte first on the wire.
    function automatic logic [WORD_BITS-1:0] swap_bytes(input logic [WORD_BITS-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall pulses, edges masked until the chain has settled
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   armed;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
            armed <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
            armed <= {armed[STAGES-1:0], 1'b1};
        end
    end

    // After reset the chain flushes from RST_VAL to the real pin level; that is not an edge.
    assign q    = chain[STAGES-1];
    assign rise = armed[STAGES] &  q & ~prev;
    assign fall = armed[STAGES] & ~q &  prev;

endmodule

// File: rtl/spi_bus_bridge.sv
// rtl/spi_bus_bridge.sv - SPI slave that turns header+data frames into single-cycle bus reads and writes
module spi_bus_bridge
    import spi_bus_bridge_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [15:0]       bus_rdata
);

    logic sck_q, sck_rise, sck_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
        .clk(clk), .resetn(resetn), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .resetn(resetn), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .d(mosi), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t                  state;
    logic [4:0]              bit_cnt;
    logic [WORD_BITS-2:0]    rx_shift;
    logic [WORD_BITS-1:0]    tx_shift;
    logic                    hdr_rnw;
    logic                    hdr_autoinc;
    logic                    re_pend;
    logic [RD_LATENCY-1:0]   rd_pipe;

    logic [WORD_BITS-1:0]    word;
    logic                    last_bit;
    logic [RD_LATENCY:0]     rd_chain;
    logic [WORD_BITS-1:0]    tx_next;

    assign word     = {rx_shift, mosi_q};
    assign last_bit = (bit_cnt == 5'(WORD_BITS - 1));
    assign rd_chain = {rd_pipe, bus_re};
    // A load landing on the same clock as a falling sck still drives its MSB out.
    assign tx_next  = rd_pipe[RD_LATENCY-1] ? swap_bytes(bus_rdata) : tx_shift;
    assign miso_oe  = ~ss_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hdr_rnw     <= 1'b0;
            hdr_autoinc <= 1'b0;
            re_pend     <= 1'b0;
            rd_pipe     <= '0;
            miso        <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_we      <= 1'b0;
            bus_re      <= 1'b0;
        end else begin
            bus_we  <= 1'b0;
            bus_re  <= 1'b0;
            rd_pipe <= rd_chain[RD_LATENCY-1:0];

            // Strobes and loads already in flight finish regardless of ss.
            if (re_pend) begin
                bus_re  <= 1'b1;
                re_pend <= 1'b0;
            end
            if (bus_we && hdr_autoinc)
                bus_addr <= bus_addr + ADDR_W'(1);

            if (sck_fall && state == ST_DATA && hdr_rnw) begin
                miso     <= tx_next[WORD_BITS-1];
                tx_shift <= {tx_next[WORD_BITS-2:0], 1'b0};
            end else begin
                tx_shift <= tx_next;
            end

            if (ss_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ss_fall) begin
                            state   <= ST_HEADER;
                            bit_cnt <= '0;
                            miso    <= 1'b0;
                        end
                    end
                    ST_HEADER: begin
                        if (sck_rise) begin
                            rx_shift <= word[WORD_BITS-2:0];
                            if (last_bit) begin
                                bit_cnt     <= '0;
                                bus_addr    <= word[HDR_ADDR_LSB +: ADDR_W];
                                hdr_autoinc <= word[HDR_AUTOINC];
                                hdr_rnw     <= word[HDR_RNW];
                                bus_re      <= word[HDR_RNW];
                                state       <= ST_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise) begin
                            rx_shift <= word[WORD_BITS-2:0];
                            if (last_bit) begin
                                bit_cnt <= '0;
                                if (hdr_rnw) begin
                                    re_pend <= 1'b1;
                                    if (hdr_autoinc)
                                        bus_addr <= bus_addr + ADDR_W'(1);
                                end else begin
                                    bus_we    <= 1'b1;
                                    bus_wdata <= swap_bytes(word);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb/tb_spi_bus_bridge.sv - scoreboard bench for spi_bus_bridge driving SPI frames against a bus model
module tb_spi_bus_bridge;

    localparam int ADDR_W = 14;
    localparam int HALF   = 6;
    localparam int GAP    = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              sck, ss, mosi;
    logic              miso, miso_oe;
    logic [ADDR_W-1:0] bus_addr;
    logic [15:0]       bus_wdata;
    logic              bus_we, bus_re;
    logic [15:0]       bus_rdata;

    int checks   = 0;
    int failures = 0;

    logic [29:0]       exp_we[$];
    logic [ADDR_W-1:0] exp_re[$];

    spi_bus_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .RD_LATENCY(1)) dut (
        .clk(clk), .resetn(resetn), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [ADDR_W-1:0] a);
        return 16'hA5C3 ^ {2'b00, a ^ 14'h3001};
    endfunction

    always @(posedge clk) bus_rdata <= bus_re ? model(bus_addr) : 16'h0BAD;

    always @(negedge clk) begin
        logic [29:0]       ew;
        logic [ADDR_W-1:0] er;
        if (resetn) begin
            if (bus_we && bus_re) begin
                checks++; failures++;
                $display("FAIL we_re_overlap: both strobes high at addr %h", bus_addr);
            end
            if (bus_we) begin
                checks++;
                if (exp_we.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_we: addr=%h data=%h, none required", bus_addr, bus_wdata);
                end else begin
                    ew = exp_we.pop_front();
                    if ({bus_addr, bus_wdata} !== ew) begin
                        failures++;
                        $display("FAIL we_beat: got addr=%h data=%h, required addr=%h data=%h",
                                 bus_addr, bus_wdata, ew[29:16], ew[15:0]);
                    end
                end
            end
            if (bus_re) begin
                checks++;
                if (exp_re.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_re: addr=%h, none required", bus_addr);
                end else begin
                    er = exp_re.pop_front();
                    if (bus_addr !== er) begin
                        failures++;
                        $display("FAIL re_addr: got %h, required %h", bus_addr, er);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 15; i > 15 - nbits; i--) begin
            sck  = 1'b0;
            mosi = tx[i];
            wait_clk(HALF);
            rx[i] = miso;
            sck = 1'b1;
            wait_clk(HALF);
        end
        wait_clk(GAP);
    endtask

    task automatic frame_start();
        ss = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_end();
        wait_clk(2);
        ss = 1'b1;
        wait_clk(12);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_we.size() != 0 || exp_re.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: we left=%0d re left=%0d, required 0 and 0",
                     name, exp_we.size(), exp_re.size());
        end
        exp_we.delete();
        exp_re.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({miso, miso_oe, bus_addr, bus_wdata, bus_we, bus_re} !== '0) begin
            failures++;
            $display("FAIL %s: miso=%b oe=%b addr=%h wdata=%h we=%b re=%b, required all 0",
                     name, miso, miso_oe, bus_addr, bus_wdata, bus_we, bus_re);
        end
    endtask

    task automatic do_write(input string name, input logic [ADDR_W-1:0] addr,
                            input logic ai, input logic [15:0] data[$]);
        logic [15:0]       rx;
        logic [ADDR_W-1:0] a;
        a = addr;
        foreach (data[k]) begin
            exp_we.push_back({a, data[k]});
            if (ai) a = a + ADDR_W'(1);
        end
        frame_start();
        spi_xfer({addr, ai, 1'b0}, 16, rx);
        checks++;
        if (miso_oe !== 1'b1 || miso !== 1'b0) begin
            failures++;
            $display("FAIL %s_pins: oe=%b miso=%b, required oe=1 miso=0", name, miso_oe, miso);
        end
        foreach (data[k]) spi_xfer({data[k][7:0], data[k][15:8]}, 16, rx);
        frame_end();
        check_drained(name);
    endtask

    task automatic do_read(input string name, input logic [ADDR_W-1:0] addr,
                           input logic ai, input int nwords);
        logic [15:0]       rx;
        logic [15:0]       exp_bits;
        logic [15:0]       mv;
        logic [ADDR_W-1:0] a;
        for (int k = 0; k <= nwords; k++)
            exp_re.push_back(ai ? addr + ADDR_W'(k) : addr);
        frame_start();
        spi_xfer({addr, ai, 1'b1}, 16, rx);
        for (int k = 0; k < nwords; k++) begin
            a  = ai ? addr + ADDR_W'(k) : addr;
            mv = model(a);
            exp_bits = {mv[7:0], mv[15:8]};
            spi_xfer(16'h0000, 16, rx);
            checks++;
            if (rx !== exp_bits) begin
                failures++;
                $display("FAIL %s_miso[%0d]: got %h, required %h", name, k, rx, exp_bits);
            end
        end
        frame_end();
        check_drained(name);
    endtask

    task automatic test_reset();
        resetn = 1'b0; ss = 1'b1; sck = 1'b1; mosi = 1'b0;
        wait_clk(5);
        check_reset_outputs("reset_state");
        resetn = 1'b1;
        wait_clk(5);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_single_write();
        logic [15:0] d[$];
        d = '{16'h0050};
        do_write("single_write", 14'h3003, 1'b0, d);
        checks++;
        if (bus_wdata !== 16'h0050) begin
            failures++;
            $display("FAIL single_write_hold: wdata=%h, required 0050", bus_wdata);
        end
    endtask

    task automatic test_single_read();
        do_read("single_read", 14'h3001, 1'b0, 1);
    endtask

    task automatic test_burst_write();
        logic [15:0] d[$];
        d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        do_write("burst_write", 14'h0000, 1'b1, d);
    endtask

    task automatic test_burst_read_wrap();
        do_read("burst_read_wrap", 14'h3FFE, 1'b1, 3);
    endtask

    task automatic test_abort();
        logic [15:0] rx;
        logic [15:0] d[$];
        frame_start();
        spi_xfer({14'h0222, 1'b0, 1'b0}, 16, rx);
        spi_xfer(16'hEEEE, 8, rx);
        frame_end();
        check_drained("abort_partial");
        d = '{16'h1234};
        do_write("after_abort", 14'h0001, 1'b0, d);
    endtask

    task automatic test_reset_mid_header();
        logic [15:0] rx;
        logic [15:0] d[$];
        frame_start();
        spi_xfer({14'h1555, 1'b1, 1'b0}, 8, rx);
        resetn = 1'b0;
        wait_clk(3);
        check_reset_outputs("reset_mid_header");
        resetn = 1'b1;
        wait_clk(6);
        checks++;
        if (bus_we !== 1'b0 || bus_re !== 1'b0 || bus_addr !== '0) begin
            failures++;
            $display("FAIL reset_rearm: we=%b re=%b addr=%h, required 0 0 0000", bus_we, bus_re, bus_addr);
        end
        ss = 1'b1;
        wait_clk(12);
        d = '{16'hBEEF, 16'h0F0F};
        do_write("post_reset_write", 14'h0123, 1'b1, d);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write();
        test_burst_read_wrap();
        test_abort();
        test_reset_mid_header();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
